// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    F_MUL, F_MULH, F_MULHSU, F_MULHU, F_DIV, F_DIVU, F_REM, F_REMU
  } funct3_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  localparam int ITER = 32;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and the muldiv unit
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = 32);
  logic start;
  funct3_e funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] y;
  modport master(output start, funct3, a, b, input busy, done, y);
  modport slave(input start, funct3, a, b, output busy, done, y);
endinterface

// File: rtl/muldiv_sign.sv
// muldiv_sign: sign extraction with magnitude at issue, forced negation at result fix-up
module muldiv_sign #(parameter int W = 64) (
  input logic [W-1:0] v,
  input logic sgn,
  input logic flip,
  output logic neg,
  output logic [W-1:0] res
);
  assign neg = sgn & v[W-1];
  assign res = (neg | flip) ? -v : v;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply (shift-add) and divide (restoring), one bit per cycle
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  muldiv_if.slave io
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(ITER);
  state_e state;
  funct3_e op;
  logic [CW-1:0] cnt;
  logic [DW-1:0] acc;
  logic [WIDTH-1:0] m;
  logic nq, nr;
  logic fixing, accept, sa_en, sb_en, sa, sb, dz, ov;
  logic [DW-1:0] ra, rb, nxt;
  logic [WIDTH:0] add, diff;
  logic [WIDTH-1:0] sy, fy;
  assign fixing = state == FIX;
  assign accept = io.start && (state == IDLE || state == DONE);
  assign sa_en = io.funct3[2] ? !io.funct3[0] : io.funct3[1:0] != 2'b11;
  assign sb_en = io.funct3[2] ? !io.funct3[0] : !io.funct3[1];
  // during FIX the same negators are reused on the accumulator halves
  muldiv_sign #(.W(DW)) u_a (
    .v(fixing ? acc : {{WIDTH{io.a[WIDTH-1]}}, io.a}),
    .sgn(sa_en && !fixing), .flip(fixing && nq), .neg(sa), .res(ra)
  );
  muldiv_sign #(.W(DW)) u_b (
    .v(fixing ? {acc[DW-1:WIDTH], {WIDTH{1'b0}}} : {{WIDTH{io.b[WIDTH-1]}}, io.b}),
    .sgn(sb_en && !fixing), .flip(fixing && nr), .neg(sb), .res(rb)
  );
  assign dz = io.funct3[2] && io.b == '0;
  assign ov = io.funct3[2] && !io.funct3[0] && io.a == {1'b1, {(WIDTH-1){1'b0}}} && io.b == '1;
  assign sy = dz ? (io.funct3[1] ? io.a : '1) : (io.funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});
  assign add = acc[0] ? {1'b0, acc[DW-1:WIDTH]} + {1'b0, m} : {1'b0, acc[DW-1:WIDTH]};
  assign diff = acc[DW-1:WIDTH-1] - {1'b0, m};
  assign nxt = op[2] ? (diff[WIDTH] ? {acc[DW-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                     : {add, acc[WIDTH-1:1]};
  assign fy = op[2] ? (op[1] ? rb[DW-1:WIDTH] : ra[WIDTH-1:0])
                    : (op[1:0] == 2'b00 ? ra[WIDTH-1:0] : ra[DW-1:WIDTH]);
  assign io.busy = state == CALC || fixing;
  assign io.done = state == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      op <= F_MUL;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      nq <= 1'b0;
      nr <= 1'b0;
      io.y <= '0;
    end else if (accept) begin
      op <= io.funct3;
      nq <= sa ^ sb;
      nr <= sa;
      cnt <= '0;
      m <= io.funct3[2] ? rb[WIDTH-1:0] : ra[WIDTH-1:0];
      acc <= {{WIDTH{1'b0}}, io.funct3[2] ? ra[WIDTH-1:0] : rb[WIDTH-1:0]};
      if (dz || ov) begin
        io.y <= sy;
        state <= DONE;
      end else state <= CALC;
    end else if (state == CALC) begin
      acc <= nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(ITER - 1)) state <= FIX;
    end else if (fixing) begin
      io.y <= fy;
      state <= DONE;
    end else if (state == DONE) state <= IDLE;
endmodule
